harvard_core_p: RTL and testbench

Parametrised accumulator-based Harvard CPU core. It is the successor of the fixed 8-bit CPU, with generic data, program-address and data-address widths. It fetches from a synchronous-read program memory and accesses data memory over a req/ack handshake, so wait states are supported. It is the top compute block; program and data memories sit outside it.

---
 rtl/harvard_pkg.sv | 40 ++++
 rtl/harvard_core_p_alu.sv | 34 +++
 rtl/harvard_core_p.sv | 159 +++++++++++++++
 tb/tb_harvard_core_p.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/harvard_pkg.sv
// Shared definitions for the parametrised accumulator Harvard core.
// Holds the opcode map, the FSM state type and the flag bit positions.
// Nothing here carries state. Flow control lives in the core.
package harvard_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_JC  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM_WAIT,
    HALT
  } state_t;

  // Bit positions inside flags_dbg = {C,Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

  // Opcodes LD..XOR take their operand from data memory.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op >= OP_LD) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/harvard_core_p_alu.sv
// Combinational ALU: result/carry for the accumulator datapath.
// Latency: zero cycles, purely combinational.
// No handshake; the core decides when the result is written.
module alu_p
  import harvard_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] result,
  output logic              cout
);

  // Loads pass b straight through; ops that do not define carry keep cin.
  always_comb begin
    result = b;
    cout   = cin;
    case (op)
      OP_ADD:  {cout, result} = {1'b0, a} + {1'b0, b};
      OP_SUB:  {cout, result} = {1'b0, a} - {1'b0, b};
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SHL:  {cout, result} = {a, 1'b0};
      OP_SHR:  {result, cout} = {1'b0, a};
      default: ;
    endcase
  end

endmodule

// File: rtl/harvard_core_p.sv
// Accumulator Harvard CPU: fetch/decode/execute with a req/ack data port.
// Latency: 3 cycles per register op, 4 + wait states per memory op.
// Data access stalls in MEM_WAIT with the bus held until mem_ack.
module harvard_core_p
  import harvard_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int PADDR_W = 8,
  parameter  int DADDR_W = 8,
  localparam int IW      = 4 + DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PADDR_W-1:0] prog_addr,
  input  logic [IW-1:0]      prog_data,
  output logic               mem_req,
  output logic               mem_we,
  output logic [DADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ack,
  output logic               halted,
  output logic [DATA_W-1:0]  acc_dbg,
  output logic [1:0]         flags_dbg
);

  state_t              state_q, state_d;
  logic [PADDR_W-1:0]  pc_q;
  logic [IW-1:0]       ir_q;
  logic [DATA_W-1:0]   acc_q;
  logic                c_q, z_q;
  logic                req_q, we_q;
  logic [DADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                ld_ir, take_jump, acc_wr, mem_issue, mem_done;
  logic [3:0]          opcode;
  logic [DATA_W-1:0]   operand;
  logic [DATA_W-1:0]   alu_b, alu_res;
  logic                alu_cout;

  assign opcode  = ir_q[IW-1:DATA_W];
  assign operand = ir_q[DATA_W-1:0];

  // Memory ops see the returned read data; register ops see the immediate.
  assign alu_b = (state_q == MEM_WAIT) ? mem_rdata : operand;

  alu_p #(.DATA_W(DATA_W)) u_alu (
    .op     (opcode),
    .a      (acc_q),
    .b      (alu_b),
    .cin    (c_q),
    .result (alu_res),
    .cout   (alu_cout)
  );

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d   = state_q;
    ld_ir     = 1'b0;
    take_jump = 1'b0;
    acc_wr    = 1'b0;
    mem_issue = 1'b0;
    mem_done  = 1'b0;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        ld_ir   = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        if (is_mem_op(opcode)) begin
          mem_issue = 1'b1;
          state_d   = MEM_WAIT;
        end else begin
          state_d = FETCH;
          case (opcode)
            OP_LDI, OP_NOT, OP_SHL, OP_SHR: acc_wr = 1'b1;
            OP_JMP:  take_jump = 1'b1;
            OP_JZ:   take_jump = z_q;
            OP_JC:   take_jump = c_q;
            OP_HLT:  state_d = HALT;
            default: ;
          endcase
        end
      end
      MEM_WAIT: begin
        // Ack is only meaningful here; elsewhere it is ignored.
        if (mem_ack) begin
          mem_done = 1'b1;
          acc_wr   = (opcode != OP_ST);
          state_d  = FETCH;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Instruction register and PC; a taken jump overrides the incremented PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
      ir_q <= '0;
    end else if (ld_ir) begin
      ir_q <= prog_data;
      pc_q <= pc_q + 1'b1;
    end else if (take_jump) begin
      pc_q <= operand[PADDR_W-1:0];
    end
  end

  // Accumulator and flags; Z tracks every ACC write, C comes from the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      c_q   <= 1'b0;
      z_q   <= 1'b0;
    end else if (acc_wr) begin
      acc_q <= alu_res;
      c_q   <= alu_cout;
      z_q   <= (alu_res == '0);
    end
  end

  // Data bus: launched in EXEC, frozen through MEM_WAIT, request dropped after ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (mem_issue) begin
      req_q   <= 1'b1;
      we_q    <= (opcode == OP_ST);
      addr_q  <= operand[DADDR_W-1:0];
      wdata_q <= acc_q;
    end else if (mem_done) begin
      req_q <= 1'b0;
      we_q  <= 1'b0;
    end
  end

  assign prog_addr = pc_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign halted    = (state_q == HALT);
  assign acc_dbg   = acc_q;
  assign flags_dbg = {c_q, z_q};

endmodule

// File: tb/tb_harvard_core_p.sv
module tb_harvard_core_p;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  prog_addr;
  logic [11:0] prog_data = '0;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr, mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        halted;
  logic [7:0]  acc_dbg;
  logic [1:0]  flags_dbg;

  logic        rst16_n;
  logic [9:0]  prog_addr16;
  logic [19:0] prog_data16 = '0;
  logic        mem_req16, mem_we16;
  logic [11:0] mem_addr16;
  logic [15:0] mem_wdata16;
  logic [15:0] mem_rdata16 = 16'h0001;
  logic        mem_ack16 = 1'b0;
  logic        halted16;
  logic [15:0] acc_dbg16;
  logic [1:0]  flags_dbg16;

  logic [11:0] pmem8  [256];
  logic [19:0] pmem16 [1024];
  logic [7:0]  dmem   [256];
  logic [7:0]  mdm    [256];

  int wait_n = 0;
  int cnt = 0;
  logic spur_ack = 1'b0;
  logic spur16 = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  harvard_core_p dut8 (
    .clk(clk), .rst_n(rst_n), .prog_addr(prog_addr), .prog_data(prog_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .halted(halted),
    .acc_dbg(acc_dbg), .flags_dbg(flags_dbg)
  );

  harvard_core_p #(.DATA_W(16), .PADDR_W(10), .DADDR_W(12)) dut16 (
    .clk(clk), .rst_n(rst16_n), .prog_addr(prog_addr16), .prog_data(prog_data16),
    .mem_req(mem_req16), .mem_we(mem_we16), .mem_addr(mem_addr16), .mem_wdata(mem_wdata16),
    .mem_rdata(mem_rdata16), .mem_ack(mem_ack16), .halted(halted16),
    .acc_dbg(acc_dbg16), .flags_dbg(flags_dbg16)
  );

  // Synchronous-read program memories.
  always @(posedge clk) begin
    prog_data   <= pmem8[prog_addr];
    prog_data16 <= pmem16[prog_addr16];
  end

  // Data memory responder for the 8-bit core: ack after wait_n idle cycles.
  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ack = spur_ack;
      cnt = 0;
    end else if (cnt >= wait_n) begin
      mem_ack = 1'b1;
      mem_rdata = dmem[mem_addr];
      if (mem_we) dmem[mem_addr] = mem_wdata;
    end else begin
      mem_ack = 1'b0;
      cnt++;
    end
  end

  // Zero-wait responder for the 16-bit core, optionally acking spuriously.
  always @(negedge clk) mem_ack16 = mem_req16 | spur16;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ins(input logic [3:0] op, input logic [7:0] opd);
    return {op, opd};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) pmem8[i] = 12'hF00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_halt(input int maxc, output int cyc, output int reqc, output int addr_chg);
    logic [7:0] a0;
    a0 = '0;
    cyc = 0; reqc = 0; addr_chg = 0;
    while (cyc < maxc) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_req) begin
        if (reqc == 0) a0 = mem_addr;
        else if (mem_addr !== a0) addr_chg++;
        reqc++;
      end
      if (halted) break;
    end
  endtask

  // ISA-level interpreter: one instruction per step, cycles from the timing rules.
  task automatic model_run(input int w, output logic [7:0] acc, output logic [1:0] fl, output int cyc);
    int pc, t;
    logic c, z;
    logic [3:0] op;
    logic [7:0] opd, m;
    pc = 0; acc = 0; c = 0; z = 0; cyc = 0;
    for (int s = 0; s < 1000; s++) begin
      op = pmem8[pc][11:8];
      opd = pmem8[pc][7:0];
      pc = (pc + 1) % 256;
      cyc += 3;
      if (op >= 4'h2 && op <= 4'h8) cyc += 1 + w;
      m = mdm[opd];
      if (op == 4'hF) break;
      case (op)
        4'h1: acc = opd;
        4'h2: acc = m;
        4'h3: mdm[opd] = acc;
        4'h4: begin t = int'(acc) + int'(m); c = (t > 255); acc = 8'(t); end
        4'h5: begin c = (acc < m); acc = acc - m; end
        4'h6: acc = acc & m;
        4'h7: acc = acc | m;
        4'h8: acc = acc ^ m;
        4'h9: acc = ~acc;
        4'hA: begin c = acc[7]; acc = acc << 1; end
        4'hB: begin c = acc[0]; acc = acc >> 1; end
        4'hC: pc = opd;
        4'hD: if (z) pc = opd;
        4'hE: if (c) pc = opd;
        default: ;
      endcase
      if (op == 4'h1 || op == 4'h2 || (op >= 4'h4 && op <= 4'hB)) z = (acc == 0);
    end
    fl = {c, z};
  endtask

  initial begin
    int cyc, reqc, achg, mcyc, cyc16;
    logic [7:0] macc;
    logic [1:0] mfl;
    logic [3:0] op;
    logic [7:0] opd;

    rst_n = 1'b0;
    rst16_n = 1'b0;
    clear_prog();
    for (int i = 0; i < 1024; i++) pmem16[i] = 20'hF0000;
    for (int i = 0; i < 256; i++) dmem[i] = '0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_prog_addr", 32'(prog_addr), 0);
    chk("rst_acc", 32'(acc_dbg), 0);
    chk("rst_flags", 32'(flags_dbg), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);

    // Zero-wait arithmetic with carry out to zero
    clear_prog();
    pmem8[0] = ins(4'h1, 8'h05);
    pmem8[1] = ins(4'h3, 8'h10);
    pmem8[2] = ins(4'h1, 8'hFB);
    pmem8[3] = ins(4'h4, 8'h10);
    wait_n = 0;
    do_reset();
    run_until_halt(200, cyc, reqc, achg);
    chk("arith_halted", 32'(halted), 1);
    chk("arith_acc", 32'(acc_dbg), 32'h00);
    chk("arith_flags", 32'(flags_dbg), 32'h3);
    chk("arith_cycles", 32'(cyc), 17);
    chk("arith_req_cycles", 32'(reqc), 2);
    chk("arith_st_data", 32'(dmem[8'h10]), 32'h05);

    // Wait states on a load
    clear_prog();
    pmem8[0] = ins(4'h2, 8'h20);
    dmem[8'h20] = 8'hA5;
    wait_n = 3;
    do_reset();
    run_until_halt(200, cyc, reqc, achg);
    chk("wait_acc", 32'(acc_dbg), 32'hA5);
    chk("wait_flags", 32'(flags_dbg), 0);
    chk("wait_req_cycles", 32'(reqc), 4);
    chk("wait_addr_stable", 32'(achg), 0);
    chk("wait_cycles", 32'(cyc), 10);

    // Branching: taken JZ, not-taken JZ, not-taken JC
    clear_prog();
    pmem8[0]  = ins(4'h1, 8'h00);
    pmem8[1]  = ins(4'hD, 8'h07);
    pmem8[7]  = ins(4'h1, 8'h01);
    pmem8[8]  = ins(4'hD, 8'h02);
    pmem8[9]  = ins(4'hE, 8'h02);
    pmem8[10] = ins(4'h1, 8'h33);
    wait_n = 0;
    do_reset();
    repeat (6) @(posedge clk); #1;
    chk("jz_taken_addr", 32'(prog_addr), 32'h07);
    repeat (6) @(posedge clk); #1;
    chk("jz_not_taken_addr", 32'(prog_addr), 32'h09);
    repeat (3) @(posedge clk); #1;
    chk("jc_not_taken_addr", 32'(prog_addr), 32'h0A);
    run_until_halt(200, cyc, reqc, achg);
    chk("branch_acc", 32'(acc_dbg), 32'h33);

    // PC wrap at the top of program space
    clear_prog();
    pmem8[0]   = ins(4'hC, 8'hFF);
    pmem8[255] = ins(4'h0, 8'h00);
    do_reset();
    repeat (3) @(posedge clk); #1;
    chk("wrap_jmp_addr", 32'(prog_addr), 32'hFF);
    repeat (3) @(posedge clk); #1;
    chk("wrap_addr", 32'(prog_addr), 32'h00);

    // Shifts through carry
    clear_prog();
    pmem8[0] = ins(4'h1, 8'h81);
    pmem8[1] = ins(4'hA, 8'h00);
    pmem8[2] = ins(4'hB, 8'h00);
    do_reset();
    repeat (6) @(posedge clk); #1;
    chk("shl_acc", 32'(acc_dbg), 32'h02);
    chk("shl_flags", 32'(flags_dbg), 32'h2);
    repeat (3) @(posedge clk); #1;
    chk("shr_acc", 32'(acc_dbg), 32'h01);
    chk("shr_flags", 32'(flags_dbg), 32'h0);

    // Reset asserted in the middle of a stalled access
    clear_prog();
    pmem8[0] = ins(4'h1, 8'h55);
    pmem8[1] = ins(4'h2, 8'h20);
    wait_n = 20;
    do_reset();
    repeat (6) @(posedge clk); #1;
    chk("mw_req_high", 32'(mem_req), 1);
    chk("mw_acc_before", 32'(acc_dbg), 32'h55);
    #2 rst_n = 1'b0;
    #1;
    chk("mw_rst_req", 32'(mem_req), 0);
    chk("mw_rst_acc", 32'(acc_dbg), 0);
    chk("mw_rst_pc", 32'(prog_addr), 0);
    wait_n = 0;
    spur_ack = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mw_release_addr", 32'(prog_addr), 0);
    run_until_halt(200, cyc, reqc, achg);
    chk("mw_rerun_acc", 32'(acc_dbg), 32'hA5);
    chk("mw_rerun_cycles", 32'(cyc), 10);
    spur_ack = 1'b0;

    // Random programs with forward-only jumps against the ISA model
    for (int t = 0; t < 10; t++) begin
      clear_prog();
      for (int i = 0; i < 20; i++) begin
        op = 4'($urandom_range(0, 14));
        if (op >= 4'h2 && op <= 4'h8) opd = 8'($urandom_range(0, 7));
        else if (op >= 4'hC) opd = 8'($urandom_range(i + 1, 20));
        else if ($urandom_range(0, 3) == 0) opd = 8'h00;
        else opd = 8'($urandom);
        pmem8[i] = ins(op, opd);
      end
      for (int a = 0; a < 8; a++) begin
        dmem[a] = 8'($urandom);
        mdm[a] = dmem[a];
      end
      wait_n = $urandom_range(0, 2);
      spur_ack = 1'($urandom_range(0, 1));
      model_run(wait_n, macc, mfl, mcyc);
      do_reset();
      run_until_halt(2000, cyc, reqc, achg);
      chk($sformatf("rnd%0d_halted", t), 32'(halted), 1);
      chk($sformatf("rnd%0d_acc", t), 32'(acc_dbg), 32'(macc));
      chk($sformatf("rnd%0d_flags", t), 32'(flags_dbg), 32'(mfl));
      chk($sformatf("rnd%0d_cycles", t), 32'(cyc), 32'(mcyc));
      for (int a = 0; a < 8; a++)
        chk($sformatf("rnd%0d_dmem%0d", t, a), 32'(dmem[a]), 32'(mdm[a]));
    end
    spur_ack = 1'b0;

    // Wide configuration with spurious acks outside MEM_WAIT
    pmem16[0] = {4'h1, 16'hFFFF};
    pmem16[1] = {4'h4, 16'h0ABC};
    spur16 = 1'b1;
    @(negedge clk);
    rst16_n = 1'b1;
    cyc16 = 0;
    while (cyc16 < 100 && !halted16) begin
      @(posedge clk); #1;
      cyc16++;
    end
    chk("w16_halted", 32'(halted16), 1);
    chk("w16_acc", 32'(acc_dbg16), 0);
    chk("w16_flags", 32'(flags_dbg16), 32'h3);
    chk("w16_addr", 32'(mem_addr16), 32'hABC);
    chk("w16_cycles", 32'(cyc16), 10);
    chk("w16_prog_addr", 32'(prog_addr16), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
